target_update_sched: RTL and testbench

- Write-side controller for the tagless target cache. Owns the cache's single write port.
- After reset, sweeps every entry to zero.
- Afterwards, buffers resolved branch-target updates from EX in a small FIFO. Drains them into the cache one per cycle, but only when the front-end is not stalled.
- Coalesces back-to-back updates to the same index. Reports dropped updates.

---
 rtl/target_sched_pkg.sv | 21 ++
 rtl/target_upd_fifo.sv | 55 +++++
 rtl/target_update_sched.sv | 118 +++++++++++
 tb/tb_target_update_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/target_sched_pkg.sv
// Shared types for the target-cache write scheduler: FSM states, the queued
// update entry and a pointer-width helper.
package target_sched_pkg;

  localparam int DEF_WIDTH = 10;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] index;
    logic [31:0]          target;
  } upd_entry_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/target_upd_fifo.sv
// Circular buffer of pending target updates with push, pop and tail overwrite.
// Head/tail views are combinational; state changes on the clock edge.
module target_upd_fifo
  import target_sched_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = upd_entry_t,
  localparam int PW    = ptr_width(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic        i_ovr,
  input  T            i_dat,
  output T            o_head,
  output T            o_tail,
  output logic        o_full,
  output logic        o_empty,
  output logic [PW:0] o_count
);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_cnt;
  logic [PW-1:0] w_tail_ptr;

  assign w_tail_ptr = r_wptr - 1'b1;

  // Storage carries no reset; valid data is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_dat;
    if (i_ovr)  r_mem[w_tail_ptr] <= i_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + (PW+1)'(i_push) - (PW+1)'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_tail  = r_mem[w_tail_ptr];
  assign o_full  = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;

endmodule

// File: rtl/target_update_sched.sv
// Sole writer of the tagless target cache: zero-sweeps after reset, then drains
// queued branch-target updates one per unstalled cycle, coalescing same-index tails.
module target_update_sched
  import target_sched_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     upd_valid_i,
  input  logic [WIDTH-1:0]         upd_index_i,
  input  logic [31:0]              upd_target_i,
  input  logic                     stall_i,
  output logic                     cache_we_o,
  output logic [WIDTH-1:0]         cache_widx_o,
  output logic [31:0]              cache_wdata_o,
  output logic                     init_busy_o,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic                     drop_o,
  output logic [CNT_W-1:0]         drop_cnt_o
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [WIDTH-1:0] index;
    logic [31:0]      target;
  } entry_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sweep;
  logic             r_drop;
  logic [CNT_W-1:0] r_drop_cnt;

  entry_t           w_in;
  entry_t           w_head;
  entry_t           w_tail;
  logic             w_full;
  logic             w_empty;
  logic [OCC_W-1:0] w_count;
  logic             w_pop;
  logic             w_coalesce;
  logic             w_push;
  logic             w_drop;

  assign w_in = '{index: upd_index_i, target: upd_target_i};

  target_upd_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_ovr   (w_coalesce),
    .i_dat   (w_in),
    .o_head  (w_head),
    .o_tail  (w_tail),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // A tail that is leaving this cycle must not absorb the new update.
  always_comb begin
    w_pop      = (r_state == RUN) && !w_empty && !stall_i && !rst;
    w_coalesce = upd_valid_i && !w_empty && (w_tail.index == upd_index_i) &&
                 !(w_pop && (w_count == OCC_W'(1)));
    w_push     = upd_valid_i && !w_coalesce && (!w_full || w_pop);
    w_drop     = upd_valid_i && !w_coalesce && w_full && !w_pop;
  end

  always_comb begin
    w_state_nxt   = r_state;
    cache_we_o    = 1'b0;
    cache_widx_o  = '0;
    cache_wdata_o = '0;
    case (r_state)
      INIT: begin
        cache_we_o   = !rst;
        cache_widx_o = r_sweep;
        if (r_sweep == '1) w_state_nxt = RUN;
      end
      RUN: begin
        cache_we_o = w_pop;
        if (!w_empty) begin
          cache_widx_o  = w_head.index;
          cache_wdata_o = w_head.target;
        end
      end
      default: w_state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= INIT;
      r_sweep    <= '0;
      r_drop     <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == INIT) r_sweep <= r_sweep + 1'b1;
      r_drop <= w_drop;
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign init_busy_o = (r_state == INIT);
  assign occupancy_o = w_count;
  assign drop_o      = r_drop;
  assign drop_cnt_o  = r_drop_cnt;

endmodule

// File: tb/tb_target_update_sched.sv
// Bench for target_update_sched: directed scenarios plus random traffic,
// compared each cycle against a queue-level reference model.
module tb_target_update_sched;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int NENT  = 1 << WIDTH;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   upd_valid_i;
  logic [WIDTH-1:0]       upd_index_i;
  logic [31:0]            upd_target_i;
  logic                   stall_i;
  logic                   cache_we_o;
  logic [WIDTH-1:0]       cache_widx_o;
  logic [31:0]            cache_wdata_o;
  logic                   init_busy_o;
  logic [$clog2(DEPTH):0] occupancy_o;
  logic                   drop_o;
  logic [CNT_W-1:0]       drop_cnt_o;

  target_update_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .upd_valid_i   (upd_valid_i),
    .upd_index_i   (upd_index_i),
    .upd_target_i  (upd_target_i),
    .stall_i       (stall_i),
    .cache_we_o    (cache_we_o),
    .cache_widx_o  (cache_widx_o),
    .cache_wdata_o (cache_wdata_o),
    .init_busy_o   (init_busy_o),
    .occupancy_o   (occupancy_o),
    .drop_o        (drop_o),
    .drop_cnt_o    (drop_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] tgt;
  } ment_t;

  ment_t       mq[$];
  bit          m_init;
  int          m_sweep;
  bit          m_drop;
  int          m_cnt;

  int          n_chk  = 0;
  int          n_fail = 0;

  logic        s_we, s_busy, s_drop;
  logic [31:0] s_widx, s_wdata, s_occ, s_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_init  = 1'b1;
    m_sweep = 0;
    m_drop  = 1'b0;
    m_cnt   = 0;
  endtask

  // One clock cycle: drive, check outputs mid-cycle, then advance the model.
  task automatic step(input bit v, input int idx, input logic [31:0] tgt,
                      input bit st, input bit r);
    bit    e_pop, coal, full;
    int    sz;
    ment_t e;
    @(negedge clk);
    upd_valid_i  = v;
    upd_index_i  = WIDTH'(idx);
    upd_target_i = tgt;
    stall_i      = st;
    rst          = r;
    #1;
    sz    = mq.size();
    e_pop = !r && !m_init && (sz > 0) && !st;
    chk("we",       cache_we_o,  !r && (m_init || e_pop));
    chk("busy",     init_busy_o, m_init);
    chk("occ",      occupancy_o, sz);
    chk("drop",     drop_o,      m_drop);
    chk("drop_cnt", drop_cnt_o,  m_cnt);
    if (!r) begin
      chk("widx",  cache_widx_o,  m_init ? m_sweep : (sz > 0 ? mq[0].idx : 0));
      chk("wdata", cache_wdata_o, m_init ? 32'h0 : (sz > 0 ? mq[0].tgt : 32'h0));
    end
    s_we = cache_we_o; s_busy = init_busy_o; s_drop = drop_o;
    s_widx = 32'(cache_widx_o); s_wdata = cache_wdata_o;
    s_occ = 32'(occupancy_o); s_cnt = 32'(drop_cnt_o);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      full = (sz == DEPTH);
      coal = v && sz > 0 && mq[sz-1].idx == idx && !(e_pop && sz == 1);
      if (e_pop) void'(mq.pop_front());
      m_drop = 1'b0;
      if (coal) begin
        mq[mq.size()-1].tgt = tgt;
      end else if (v) begin
        if (!full || e_pop) begin
          e.idx = idx; e.tgt = tgt;
          mq.push_back(e);
        end else begin
          m_drop = 1'b1;
          if (m_cnt < CMAX) m_cnt++;
        end
      end
      if (m_init) begin
        if (m_sweep == NENT - 1) m_init = 1'b0;
        m_sweep = (m_sweep + 1) % NENT;
      end
    end
  endtask

  task automatic idle(input bit st);
    step(1'b0, 0, 32'h0, st, 1'b0);
  endtask

  initial begin
    int we_cycles;
    int got_idx[3];
    int got_dat[3];
    rst = 1'b1; upd_valid_i = 1'b0; upd_index_i = '0; upd_target_i = '0; stall_i = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    step(1'b0, 0, 32'h0, 1'b0, 1'b1);

    // Sweep with an update pushed on its first cycle
    we_cycles = 0;
    step(1'b1, 7, 32'h2000, 1'b0, 1'b0);
    we_cycles += int'(s_we && s_busy);
    for (int i = 0; i < 40 && m_init; i++) begin
      idle(1'b0);
      we_cycles += int'(s_we && s_busy);
    end
    chk("sweep_len", we_cycles, 16);
    idle(1'b0);
    chk("init_push_we",   s_we,    1);
    chk("init_push_busy", s_busy,  0);
    chk("init_push_idx",  s_widx,  7);
    chk("init_push_dat",  s_wdata, 32'h2000);

    // Single-cycle latency
    step(1'b1, 5, 32'h1040, 1'b0, 1'b0);
    idle(1'b0);
    chk("lat_we",  s_we,    1);
    chk("lat_idx", s_widx,  5);
    chk("lat_dat", s_wdata, 32'h1040);
    idle(1'b0);
    chk("lat_occ", s_occ, 0);

    // Coalescing under stall
    step(1'b1, 1, 32'hA1, 1'b1, 1'b0);
    step(1'b1, 2, 32'hA2, 1'b1, 1'b0);
    step(1'b1, 2, 32'hB2, 1'b1, 1'b0);
    step(1'b1, 3, 32'hA3, 1'b1, 1'b0);
    idle(1'b1);
    chk("coal_occ", s_occ, 3);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      got_idx[i] = s_widx; got_dat[i] = s_wdata;
    end
    chk("coal_idx0", got_idx[0], 1);
    chk("coal_idx1", got_idx[1], 2);
    chk("coal_dat1", got_dat[1], 32'hB2);
    chk("coal_idx2", got_idx[2], 3);

    // Overflow, push-during-pop when full, counter saturation
    for (int i = 10; i < 15; i++) step(1'b1, i, 32'h100 + 32'(i), 1'b1, 1'b0);
    idle(1'b1);
    chk("ovf_drop", s_drop, 1);
    chk("ovf_cnt",  s_cnt,  1);
    chk("ovf_occ",  s_occ,  4);
    idle(1'b1);
    chk("ovf_pulse", s_drop, 0);
    step(1'b1, 15, 32'h1FF, 1'b0, 1'b0);
    idle(1'b1);
    chk("full_pop_drop", s_drop, 0);
    chk("full_pop_cnt",  s_cnt,  1);
    chk("full_pop_occ",  s_occ,  4);
    for (int i = 1; i < 5; i++) step(1'b1, i, 32'h300 + 32'(i), 1'b1, 1'b0);
    idle(1'b1);
    chk("sat_cnt", s_cnt, CMAX);
    repeat (6) idle(1'b0);

    // Reset with queued updates
    for (int i = 6; i < 9; i++) step(1'b1, i, 32'h500 + 32'(i), 1'b1, 1'b0);
    step(1'b0, 0, 32'h0, 1'b1, 1'b1);
    chk("rst_we", s_we, 0);
    idle(1'b1);
    chk("rst_occ",  s_occ,  0);
    chk("rst_busy", s_busy, 1);
    chk("rst_idx",  s_widx, 0);
    for (int i = 0; i < 40 && m_init; i++) idle(1'b0);
    repeat (3) idle(1'b0);
    chk("rst_nowrite", s_we, 0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom,
           1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
